// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Stall/flush producer for the 5-stage RISC-V pipeline. It covers the hazards
// the forwarding unit cannot resolve:
//   - load-use hazards (load in Execute feeding the instruction in Decode)
//   - taken branches/jumps resolved in Execute
//   - variable-latency data-memory loads, tracked by a wait FSM with a
//     timeout watchdog that ends in a sticky error state.
//
// Priority of events in a cycle: memory stall > taken branch > load-use.
//
// Parameters
//   MEM_TIMEOUT  max cycles in MEM_WAIT without mem_ready before MEM_ERR (>=2)
//   CNT_W        width of the performance counters
//
// Ports
//   clk, reset_n                 clock (rising edge), async active-low reset
//   Rs1_D, Rs2_D                 Decode source register addresses
//   Rs1_used_D, Rs2_used_D       Decode instruction actually reads Rs1/Rs2
//   RD_E                         Execute destination register
//   MemReadE, RegWriteE          Execute holds a load / writes the regfile
//   PCSrcE                       branch/jump taken in Execute
//   MemReadM, mem_ready          Memory-stage load request / data returned
//   StallF/D/E/M                 hold the pipeline register of that stage
//   FlushD/E/W                   turn the pipeline register into a bubble
//   mem_err                      sticky memory-timeout error (registered)
//   lw_stall_cnt, mem_stall_cnt, flush_cnt  saturating performance counters
//
// Configuration
//   HAZARD_PERF_CNT_EN  when defined, the three performance counters are
//                       implemented; otherwise the ports are tied to zero and
//                       no counter flops exist.
//
// All stall/flush outputs are forced to 0 while reset_n is low, even though
// they are combinational.
// -----------------------------------------------------------------------------
module hazard_stall_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic             Rs1_used_D,
  input  logic             Rs2_used_D,
  input  logic [4:0]       RD_E,
  input  logic             MemReadE,
  input  logic             RegWriteE,
  input  logic             PCSrcE,
  input  logic             MemReadM,
  input  logic             mem_ready,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             mem_err,
  output logic [CNT_W-1:0] lw_stall_cnt,
  output logic [CNT_W-1:0] mem_stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_ERR  = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_n;
  logic [WCNT_W-1:0] wcnt_r;
  logic [WCNT_W-1:0] wcnt_n;
  logic              mem_err_r;
  logic              mem_stall_s;
  logic              lw_stall_s;
  logic              rs1_hit_s;
  logic              rs2_hit_s;

  // Load-use detection: a register-writing load in E whose destination is a
  // real source of the instruction in D. x0 never creates a dependency.
  always_comb begin
    rs1_hit_s  = Rs1_used_D && (Rs1_D == RD_E);
    rs2_hit_s  = Rs2_used_D && (Rs2_D == RD_E);
    lw_stall_s = MemReadE && RegWriteE && (RD_E != 5'd0) && (rs1_hit_s || rs2_hit_s);
  end

  // Memory stall: the stall must drop in the very cycle mem_ready arrives, so
  // MEM_WAIT only stalls while mem_ready is low. MEM_ERR stalls forever.
  always_comb begin
    mem_stall_s = 1'b0;
    case (state_r)
      RUN:      mem_stall_s = MemReadM && !mem_ready;
      MEM_WAIT: mem_stall_s = !mem_ready;
      MEM_ERR:  mem_stall_s = 1'b1;
      default:  mem_stall_s = 1'b1;
    endcase
  end

  // Wait FSM next-state and wait-counter update.
  always_comb begin
    state_n = state_r;
    wcnt_n  = wcnt_r;
    case (state_r)
      RUN: begin
        if (MemReadM && !mem_ready) begin
          state_n = MEM_WAIT;
          wcnt_n  = WCNT_W'(1);
        end else begin
          state_n = RUN;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_n = RUN;
          wcnt_n  = '0;
        end else if (wcnt_r == WCNT_W'(MEM_TIMEOUT)) begin
          state_n = MEM_ERR;
        end else begin
          wcnt_n = wcnt_r + WCNT_W'(1);
        end
      end
      MEM_ERR: begin
        // Absorbing: only reset leaves this state.
        state_n = MEM_ERR;
      end
      default: begin
        state_n = RUN;
        wcnt_n  = '0;
      end
    endcase
  end

  // FSM state, wait counter and sticky error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= RUN;
      wcnt_r    <= '0;
      mem_err_r <= 1'b0;
    end else begin
      state_r   <= state_n;
      wcnt_r    <= wcnt_n;
      // Rises on the edge that moves the FSM into MEM_ERR, then sticks.
      mem_err_r <= mem_err_r || (state_n == MEM_ERR);
    end
  end

  assign mem_err = mem_err_r;

  // Prioritised stall/flush generation, forced quiet during reset.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (!reset_n) begin
      StallF = 1'b0;
    end else if (mem_stall_s) begin
      // Whole front of the pipe frozen; W gets a bubble. E is held, so a
      // taken branch there is seen again once memory releases.
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      // Wrong-path instructions in D and E are squashed; any load-use
      // hazard on that path is irrelevant.
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lw_stall_s) begin
      // The bubble injected into E clears the hazard on the next cycle.
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end else begin
      StallF = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic             lw_evt_s;
  logic             fl_evt_s;
  logic [CNT_W-1:0] lw_cnt_r;
  logic [CNT_W-1:0] mem_cnt_r;
  logic [CNT_W-1:0] fl_cnt_r;

  // Counter events follow the same priority as the stall/flush outputs.
  always_comb begin
    lw_evt_s = lw_stall_s && !mem_stall_s && !PCSrcE;
    fl_evt_s = PCSrcE && !mem_stall_s;
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lw_cnt_r  <= '0;
      mem_cnt_r <= '0;
      fl_cnt_r  <= '0;
    end else begin
      if (lw_evt_s && (lw_cnt_r != {CNT_W{1'b1}})) begin
        lw_cnt_r <= lw_cnt_r + CNT_W'(1);
      end
      if (mem_stall_s && (mem_cnt_r != {CNT_W{1'b1}})) begin
        mem_cnt_r <= mem_cnt_r + CNT_W'(1);
      end
      if (fl_evt_s && (fl_cnt_r != {CNT_W{1'b1}})) begin
        fl_cnt_r <= fl_cnt_r + CNT_W'(1);
      end
    end
  end

  assign lw_stall_cnt  = lw_cnt_r;
  assign mem_stall_cnt = mem_cnt_r;
  assign flush_cnt     = fl_cnt_r;
`else
  assign lw_stall_cnt  = '0;
  assign mem_stall_cnt = '0;
  assign flush_cnt     = '0;
`endif

endmodule
